router_fsm_n: RTL and testbench



---
 rtl/router_pkg.sv | 25 ++
 rtl/router_fsm_n_if.sv | 39 +++
 rtl/router_fsm_n.sv | 108 ++++++++++
 tb/tb_router_fsm_n.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encoding, default sizes and the
// address-width helper used by the router blocks.
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    localparam int NUM_PORTS_DEF    = 3;
    localparam int WAIT_TIMEOUT_DEF = 64;

    // Minimum address width able to select n ports (never below one bit).
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_fsm_n_if.sv
// Control bundle between the router FSM and its input-register / FIFO neighbours.
interface router_fsm_n_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 packet_valid;
    logic [ADDR_W-1:0]    datain;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_packet_valid;

    logic                 write_enb_reg;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 busy;
    logic                 drop_state;
    logic [ADDR_W-1:0]    addr_sel;
    logic [3:0]           current_state;

    modport master (
        output packet_valid, datain, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, busy, drop_state, addr_sel, current_state
    );

    modport slave (
        input  packet_valid, datain, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
               full_state, rst_int_reg, busy, drop_state, addr_sel, current_state
    );
endinterface

// File: rtl/router_fsm_n.sv
// 1xN router control FSM: header decode, payload/parity sequencing, FIFO-full
// handling, invalid-address drop and wait-till-empty timeout.
module router_fsm_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS    = NUM_PORTS_DEF,
    parameter int ADDR_W       = addr_w(NUM_PORTS_DEF),
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    router_fsm_n_if.slave bus
);

    localparam int NSEL  = 2 ** ADDR_W;
    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    state_t            state, nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              drop_tail;
    logic [NSEL-1:0]   empty_ext, sreset_ext;
    logic              timeout, sel_sreset, bad_addr;

    // Pad per-port flags to the full address space so any address indexes safely.
    always_comb begin
        empty_ext                   = '0;
        sreset_ext                  = '0;
        empty_ext[NUM_PORTS-1:0]    = bus.fifo_empty;
        sreset_ext[NUM_PORTS-1:0]   = bus.soft_reset;
    end

    assign timeout    = (WAIT_TIMEOUT > 0) && (int'(wait_cnt) == WAIT_TIMEOUT - 1);
    assign sel_sreset = sreset_ext[bus.addr_sel];
    assign bad_addr   = int'(bus.datain) >= NUM_PORTS;

    always_comb begin
        nxt = state;
        case (state)
            DECODE_ADDRESS:
                if (bus.packet_valid) begin
                    if (bad_addr)                    nxt = DROP_PACKET;
                    else if (empty_ext[bus.datain])  nxt = LOAD_FIRST_DATA;
                    else                             nxt = WAIT_TILL_EMPTY;
                end
            WAIT_TILL_EMPTY:
                if (empty_ext[bus.addr_sel]) nxt = LOAD_FIRST_DATA;
                else if (timeout)            nxt = DROP_PACKET;
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)          nxt = FIFO_FULL_STATE;
                else if (!bus.packet_valid) nxt = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)           nxt = DECODE_ADDRESS;
                else if (bus.low_packet_valid) nxt = LOAD_PARITY;
                else                           nxt = LOAD_DATA;
            LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            // drop_tail marks the extra cycle that swallows the parity byte
            DROP_PACKET:
                if (drop_tail) nxt = DECODE_ADDRESS;
            default: nxt = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && state != DROP_PACKET && sel_sreset)
            nxt = DECODE_ADDRESS;
    end

    assign bus.current_state = state;

    // Outputs are registered from nxt so they equal a decode of state with no lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= DECODE_ADDRESS;
            bus.addr_sel      <= '0;
            wait_cnt          <= '0;
            drop_tail         <= 1'b0;
            bus.detect_add    <= 1'b1;
            bus.lfd_state     <= 1'b0;
            bus.ld_state      <= 1'b0;
            bus.laf_state     <= 1'b0;
            bus.full_state    <= 1'b0;
            bus.rst_int_reg   <= 1'b0;
            bus.drop_state    <= 1'b0;
            bus.write_enb_reg <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDRESS && nxt != DECODE_ADDRESS)
                bus.addr_sel <= bus.datain;
            wait_cnt  <= (state == WAIT_TILL_EMPTY && nxt == WAIT_TILL_EMPTY) ?
                         wait_cnt + 1'b1 : '0;
            drop_tail <= (state == DROP_PACKET) && !bus.packet_valid && !drop_tail;
            bus.detect_add    <= nxt == DECODE_ADDRESS;
            bus.lfd_state     <= nxt == LOAD_FIRST_DATA;
            bus.ld_state      <= nxt == LOAD_DATA;
            bus.laf_state     <= nxt == LOAD_AFTER_FULL;
            bus.full_state    <= nxt == FIFO_FULL_STATE;
            bus.rst_int_reg   <= nxt == CHECK_PARITY_ERROR;
            bus.drop_state    <= nxt == DROP_PACKET;
            bus.write_enb_reg <= (nxt == LOAD_DATA) || (nxt == LOAD_PARITY) ||
                                 (nxt == LOAD_AFTER_FULL);
            bus.busy          <= !((nxt == DECODE_ADDRESS) || (nxt == LOAD_DATA) ||
                                   (nxt == DROP_PACKET));
        end
    end

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed bench for router_fsm_n: one DUT with the default timeout, one with
// WAIT_TIMEOUT=4 for the timeout path.
module tb_router_fsm_n;
    import router_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    router_fsm_n_if #(.NUM_PORTS(3), .ADDR_W(2)) if_a ();
    router_fsm_n_if #(.NUM_PORTS(3), .ADDR_W(2)) if_b ();

    router_fsm_n #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(64)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    router_fsm_n #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    task automatic idle();
        if_a.packet_valid = 0; if_a.datain = '0; if_a.fifo_full = 0;
        if_a.fifo_empty = 3'b111; if_a.soft_reset = '0; if_a.parity_done = 0;
        if_a.low_packet_valid = 0;
        if_b.packet_valid = 0; if_b.datain = '0; if_b.fifo_full = 0;
        if_b.fifo_empty = 3'b111; if_b.soft_reset = '0; if_b.parity_done = 0;
        if_b.low_packet_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        tick();
        n_vec++; if (if_a.current_state !== 4'd0) begin n_err++;
            $display("FAIL reset state got %0d want 0", if_a.current_state); end
        n_vec++; if (if_a.detect_add !== 1'b1) begin n_err++;
            $display("FAIL reset detect_add got %b want 1", if_a.detect_add); end
        n_vec++; if ({if_a.busy, if_a.write_enb_reg, if_a.drop_state, if_a.lfd_state} !== 4'b0) begin
            n_err++; $display("FAIL reset flags got %b want 0000",
                {if_a.busy, if_a.write_enb_reg, if_a.drop_state, if_a.lfd_state}); end
        n_vec++; if (if_a.addr_sel !== 2'd0) begin n_err++;
            $display("FAIL reset addr_sel got %0d want 0", if_a.addr_sel); end
        reset = 0;
        tick();
        n_vec++; if (if_a.current_state !== 4'd0 || if_b.current_state !== 4'd0) begin n_err++;
            $display("FAIL idle_hold state got %0d/%0d want 0/0", if_a.current_state, if_b.current_state); end
    endtask

    task automatic test_normal();
        bit pv_t [7];
        int st_t [7];
        bit we_t [7];
        bit bz_t [7];
        pv_t = '{1, 1, 1, 1, 0, 0, 0};
        st_t = '{1, 2, 2, 2, 5, 6, 0};
        we_t = '{0, 1, 1, 1, 1, 0, 0};
        bz_t = '{1, 0, 0, 0, 1, 1, 0};
        idle();
        if_a.datain = 2'd0;
        if_a.fifo_empty = 3'b001;
        for (int i = 0; i < 7; i++) begin
            if_a.packet_valid = pv_t[i];
            if_a.parity_done  = (i == 5);
            tick();
            n_vec++; if (int'(if_a.current_state) != st_t[i]) begin n_err++;
                $display("FAIL normal[%0d] state got %0d want %0d", i, if_a.current_state, st_t[i]); end
            n_vec++; if (if_a.write_enb_reg !== we_t[i] || if_a.busy !== bz_t[i]) begin n_err++;
                $display("FAIL normal[%0d] we/busy got %b%b want %b%b", i,
                    if_a.write_enb_reg, if_a.busy, we_t[i], bz_t[i]); end
        end
        n_vec++; if (if_a.addr_sel !== 2'd0) begin n_err++;
            $display("FAIL normal addr_sel got %0d want 0", if_a.addr_sel); end
    endtask

    task automatic test_wait();
        bit       pv_t [10];
        logic [2:0] em_t [10];
        int       st_t [10];
        bit       bz_t [10];
        pv_t = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        em_t = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        st_t = '{7, 7, 7, 7, 7, 1, 2, 5, 6, 0};
        bz_t = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
        idle();
        if_a.datain = 2'd2;
        for (int i = 0; i < 10; i++) begin
            if_a.packet_valid = pv_t[i];
            if_a.fifo_empty   = em_t[i];
            tick();
            n_vec++; if (int'(if_a.current_state) != st_t[i] || if_a.busy !== bz_t[i]) begin n_err++;
                $display("FAIL wait[%0d] state/busy got %0d/%b want %0d/%b", i,
                    if_a.current_state, if_a.busy, st_t[i], bz_t[i]); end
            if (i == 5) begin
                n_vec++; if (if_a.addr_sel !== 2'd2) begin n_err++;
                    $display("FAIL wait addr_sel got %0d want 2", if_a.addr_sel); end
            end
        end
    endtask

    task automatic test_fifo_full();
        bit pv_t [13], ff_t [13], lp_t [13], pd_t [13];
        int st_t [13];
        pv_t = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        ff_t = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        lp_t = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        pd_t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        st_t = '{1, 2, 3, 3, 4, 2, 3, 4, 5, 6, 3, 4, 0};
        idle();
        if_a.datain = 2'd1;
        for (int i = 0; i < 13; i++) begin
            if_a.packet_valid     = pv_t[i];
            if_a.fifo_full        = ff_t[i];
            if_a.low_packet_valid = lp_t[i];
            if_a.parity_done      = pd_t[i];
            tick();
            n_vec++; if (int'(if_a.current_state) != st_t[i]) begin n_err++;
                $display("FAIL full[%0d] state got %0d want %0d", i, if_a.current_state, st_t[i]); end
            n_vec++; if (if_a.full_state !== (st_t[i] == 3) || if_a.laf_state !== (st_t[i] == 4)) begin
                n_err++; $display("FAIL full[%0d] full/laf got %b%b want %b%b", i,
                    if_a.full_state, if_a.laf_state, st_t[i] == 3, st_t[i] == 4); end
        end
        n_vec++; if (if_a.addr_sel !== 2'd1) begin n_err++;
            $display("FAIL full addr_sel got %0d want 1", if_a.addr_sel); end
        idle();
    endtask

    task automatic test_drop();
        bit pv_t [4];
        int st_t [4];
        pv_t = '{1, 1, 0, 0};
        st_t = '{8, 8, 8, 0};
        idle();
        if_a.datain = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if_a.packet_valid = pv_t[i];
            tick();
            n_vec++; if (int'(if_a.current_state) != st_t[i]) begin n_err++;
                $display("FAIL drop[%0d] state got %0d want %0d", i, if_a.current_state, st_t[i]); end
            n_vec++; if (if_a.drop_state !== (st_t[i] == 8) || if_a.busy !== 1'b0 ||
                         if_a.write_enb_reg !== 1'b0) begin n_err++;
                $display("FAIL drop[%0d] drop/busy/we got %b%b%b want %b00", i,
                    if_a.drop_state, if_a.busy, if_a.write_enb_reg, st_t[i] == 8); end
        end
        n_vec++; if (if_a.addr_sel !== 2'd3) begin n_err++;
            $display("FAIL drop addr_sel got %0d want 3", if_a.addr_sel); end
    endtask

    task automatic test_timeout();
        bit pv_t [7];
        int st_t [7];
        pv_t = '{1, 1, 1, 1, 1, 0, 0};
        st_t = '{7, 7, 7, 7, 8, 8, 0};
        idle();
        if_b.datain = 2'd1;
        if_b.fifo_empty = 3'b001;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 7; i++) begin
                if_b.packet_valid = pv_t[i];
                tick();
                n_vec++; if (int'(if_b.current_state) != st_t[i] || if_b.drop_state !== (st_t[i] == 8)) begin
                    n_err++; $display("FAIL timeout[%0d.%0d] state/drop got %0d/%b want %0d/%b", pass, i,
                        if_b.current_state, if_b.drop_state, st_t[i], st_t[i] == 8); end
            end
        end
        idle();
    endtask

    task automatic test_soft_reset();
        logic [2:0] sr_t [7];
        bit         ff_t [7];
        int         st_t [7];
        sr_t = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
        ff_t = '{0, 0, 0, 0, 0, 0, 1};
        st_t = '{1, 2, 2, 0, 1, 2, 3};
        idle();
        if_a.datain = 2'd1;
        if_a.packet_valid = 1;
        for (int i = 0; i < 7; i++) begin
            if_a.soft_reset = sr_t[i];
            if_a.fifo_full  = ff_t[i];
            tick();
            n_vec++; if (int'(if_a.current_state) != st_t[i]) begin n_err++;
                $display("FAIL soft[%0d] state got %0d want %0d", i, if_a.current_state, st_t[i]); end
        end
        reset = 1;
        tick();
        n_vec++; if (if_a.current_state !== 4'd0 || if_a.detect_add !== 1'b1 ||
                     if_a.full_state !== 1'b0 || if_a.addr_sel !== 2'd0) begin n_err++;
            $display("FAIL midreset state/det/full/addr got %0d/%b/%b/%0d want 0/1/0/0",
                if_a.current_state, if_a.detect_add, if_a.full_state, if_a.addr_sel); end
        reset = 0;
        idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_wait();
        test_fifo_full();
        test_drop();
        test_timeout();
        test_soft_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
